// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM address,
// captures the returned word into the IF/ID register and applies stall and
// redirect requests. Also keeps a retired-fetch counter and a sticky flag
// for misaligned redirect targets.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] fetch_count,
  output logic        misalign_err
);

  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        misalign_err_q, misalign_err_d;

  // Next-state selection: redirect beats stall, stall beats advance.
  always_comb begin
    pc_d           = pc_q;
    id_valid_d     = id_valid_q;
    id_pc_d        = id_pc_q;
    id_inst_d      = id_inst_q;
    fetch_count_d  = fetch_count_q;
    misalign_err_d = misalign_err_q;
    if (redirect_valid) begin
      // Low bits are dropped so the PC stays word-aligned; the flag records it.
      pc_d           = {redirect_pc[31:2], 2'b00};
      id_valid_d     = 1'b0;
      id_pc_d        = 32'h0000_0000;
      id_inst_d      = NOP_INST;
      misalign_err_d = misalign_err_q | (redirect_pc[1:0] != 2'b00);
    end else if (!stall) begin
      pc_d          = pc_q + 32'd4;
      id_valid_d    = 1'b1;
      id_pc_d       = pc_q;
      id_inst_d     = imem_inst;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      id_valid_q     <= 1'b0;
      id_pc_q        <= 32'h0000_0000;
      id_inst_q      <= NOP_INST;
      fetch_count_q  <= 32'h0000_0000;
      misalign_err_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      id_valid_q     <= id_valid_d;
      id_pc_q        <= id_pc_d;
      id_inst_q      <= id_inst_d;
      fetch_count_q  <= fetch_count_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign id_valid     = id_valid_q;
  assign id_pc        = id_pc_q;
  assign id_inst      = id_inst_q;
  assign fetch_count  = fetch_count_q;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: two instances (default reset PC and a reset PC near the
// top of the address space) share stimulus; a behavioural model checks both
// every cycle, and directed literal checks pin the model's expectations.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic [31:0] imem_addr0, imem_inst0, pc0, id_pc0, id_inst0, fetch_count0;
  logic        id_valid0, misalign_err0;
  logic [31:0] imem_addr1, imem_inst1, pc1, id_pc1, id_inst1, fetch_count1;
  logic        id_valid1, misalign_err1;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // ROM image: three given words, the rest distinct and derived from the index.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a[9:2])
      8'd0:    imem_word = 32'h8000_00b7;
      8'd1:    imem_word = 32'hfff0_8093;
      8'd2:    imem_word = 32'h0010_8113;
      default: imem_word = {a[9:2], 24'h000093};
    endcase
  endfunction

  assign imem_inst0 = imem_word(imem_addr0);
  assign imem_inst1 = imem_word(imem_addr1);

  ifetch dut0 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr0), .imem_inst(imem_inst0),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc0), .id_valid(id_valid0), .id_pc(id_pc0), .id_inst(id_inst0),
    .fetch_count(fetch_count0), .misalign_err(misalign_err0)
  );

  ifetch #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr1), .imem_inst(imem_inst1),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc1), .id_valid(id_valid1), .id_pc(id_pc1), .id_inst(id_inst1),
    .fetch_count(fetch_count1), .misalign_err(misalign_err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one entry per instance.
  logic [31:0] m_reset_pc [2];
  logic [31:0] m_pc [2];
  logic        m_valid [2];
  logic [31:0] m_idpc [2];
  logic [31:0] m_inst [2];
  logic [31:0] m_cnt [2];
  logic        m_mis [2];

  initial begin
    m_reset_pc[0] = 32'h0000_0000;
    m_reset_pc[1] = 32'hFFFF_FFF8;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pc[k] = m_reset_pc[k]; m_valid[k] = 1'b0; m_idpc[k] = 32'h0;
        m_inst[k] = 32'h13; m_cnt[k] = 32'h0; m_mis[k] = 1'b0;
      end else if (redirect_valid) begin
        m_pc[k] = redirect_pc & 32'hFFFF_FFFC;
        m_valid[k] = 1'b0; m_idpc[k] = 32'h0; m_inst[k] = 32'h13;
        if (redirect_pc % 4 != 0) m_mis[k] = 1'b1;
      end else if (!stall) begin
        m_idpc[k] = m_pc[k];
        m_inst[k] = imem_word(m_pc[k]);
        m_valid[k] = 1'b1;
        m_pc[k] = m_pc[k] + 4;
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc0", pc0, m_pc[0]);
      chk("imem_addr0", imem_addr0, m_pc[0]);
      chk("id_valid0", {31'b0, id_valid0}, {31'b0, m_valid[0]});
      chk("id_pc0", id_pc0, m_idpc[0]);
      chk("id_inst0", id_inst0, m_inst[0]);
      chk("fetch_count0", fetch_count0, m_cnt[0]);
      chk("misalign0", {31'b0, misalign_err0}, {31'b0, m_mis[0]});
      chk("pc1", pc1, m_pc[1]);
      chk("imem_addr1", imem_addr1, m_pc[1]);
      chk("id_valid1", {31'b0, id_valid1}, {31'b0, m_valid[1]});
      chk("id_pc1", id_pc1, m_idpc[1]);
      chk("id_inst1", id_inst1, m_inst[1]);
      chk("fetch_count1", fetch_count1, m_cnt[1]);
      chk("misalign1", {31'b0, misalign_err1}, {31'b0, m_mis[1]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] cnt_start;
  int budget;

  initial begin
    #2;
    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    // Reset values.
    chk("rst_pc0", pc0, 32'h0);
    chk("rst_pc1", pc1, 32'hFFFF_FFF8);
    chk("rst_valid", {31'b0, id_valid0}, 32'h0);
    chk("rst_inst", id_inst0, 32'h0000_0013);
    chk("rst_cnt", fetch_count0, 32'h0);
    chk("rst_mis", {31'b0, misalign_err0}, 32'h0);
    rst = 1'b0;

    // Free run over the first three words; also top-of-memory wrap on dut1.
    cyc();
    chk("run0_idpc", id_pc0, 32'h0);
    chk("run0_inst", id_inst0, 32'h8000_00b7);
    chk("run0_valid", {31'b0, id_valid0}, 32'h1);
    chk("wrap_pc1_a", pc1, 32'hFFFF_FFFC);
    cyc();
    chk("run1_idpc", id_pc0, 32'h4);
    chk("run1_inst", id_inst0, 32'hfff0_8093);
    chk("wrap_pc1_b", pc1, 32'h0);
    chk("wrap_idpc1", id_pc1, 32'hFFFF_FFFC);

    // Stall two cycles while id_pc = 4.
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stall_pc", pc0, 32'h8);
      chk("stall_idpc", id_pc0, 32'h4);
      chk("stall_cnt", fetch_count0, 32'd2);
    end
    stall = 1'b0;
    cyc();
    chk("resume_idpc", id_pc0, 32'h8);
    chk("resume_inst", id_inst0, 32'h0010_8113);
    chk("resume_cnt", fetch_count0, 32'd3);

    // Run until pc = 0x74, bounded.
    budget = 100;
    while (pc0 != 32'h74 && budget > 0) begin
      cyc();
      budget--;
    end
    chk("reach_0x74", pc0, 32'h74);

    // Redirect to 0x98.
    redirect_valid = 1'b1; redirect_pc = 32'h98;
    cyc();
    redirect_valid = 1'b0;
    chk("redir_pc", pc0, 32'h98);
    chk("redir_valid", {31'b0, id_valid0}, 32'h0);
    chk("redir_inst", id_inst0, 32'h0000_0013);
    cyc();
    chk("redir_idpc", id_pc0, 32'h98);
    chk("redir_valid2", {31'b0, id_valid0}, 32'h1);
    chk("redir_inst2", id_inst0, 32'h2600_0093);

    // Redirect together with stall, then a self-loop on 0xC0.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hC0;
    cyc();
    stall = 1'b0;
    chk("rs_pc", pc0, 32'hC0);
    chk("rs_valid", {31'b0, id_valid0}, 32'h0);
    cnt_start = fetch_count0;
    for (int i = 0; i < 3; i++) begin
      redirect_valid = 1'b0;
      cyc();
      chk("loop_idpc", id_pc0, 32'hC0);
      redirect_valid = 1'b1; redirect_pc = 32'hC0;
      cyc();
    end
    redirect_valid = 1'b0;
    chk("loop_cnt", fetch_count0, cnt_start + 32'd3);

    // Misaligned redirect target; flag is sticky.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0106;
    cyc();
    chk("mis_pc", pc0, 32'h104);
    chk("mis_flag", {31'b0, misalign_err0}, 32'h1);
    redirect_pc = 32'h20;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("mis_sticky", {31'b0, misalign_err0}, 32'h1);

    // Reset asserted with redirect and stall.
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h55; stall = 1'b1;
    cyc();
    rst = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    chk("rst2_pc0", pc0, 32'h0);
    chk("rst2_pc1", pc1, 32'hFFFF_FFF8);
    chk("rst2_cnt", fetch_count0, 32'h0);
    chk("rst2_mis", {31'b0, misalign_err0}, 32'h0);
    cyc();
    cyc();
    chk("post_rst_cnt", fetch_count0, 32'd2);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage of the single-issue RV32I pipeline, sitting directly upstream of the instruction memory (`imem`) and directly upstream of decode. It owns the program counter, drives the combinational ROM address, captures the returned word into the IF/ID pipeline register, and applies stall and branch/jump redirect requests from the hazard unit and execute stage. It also keeps a retired-fetch counter and a sticky misaligned-target flag for debug.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset; must be word-aligned.
- `NOP_INST`, default `32'h0000_0013`: word presented on `id_inst` when the IF/ID slot is empty (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  byte address to `imem`; combinational copy of `pc`.
- `imem_inst`  in  32  instruction word from `imem`, valid in the same cycle as `imem_addr`.
- `stall`  in  1  hold PC and IF/ID register (load-use or structural hazard).
- `redirect_valid`  in  1  taken branch/jump resolved downstream; kill wrong-path fetch.
- `redirect_pc`  in  32  redirect target byte address.
- `pc`  out  32  current fetch PC.
- `id_valid`  out  1  IF/ID slot holds a real instruction.
- `id_pc`  out  32  PC of the instruction in the IF/ID slot.
- `id_inst`  out  32  instruction in the IF/ID slot; `NOP_INST` whenever `id_valid`=0.
- `fetch_count`  out  32  number of instructions accepted into IF/ID since reset.
- `misalign_err`  out  1  sticky: a redirect target with nonzero `[1:0]` was seen.

## Operation
- Per-cycle priority: `rst` > `redirect_valid` > `stall` > advance.
- Reset: `pc`=`RESET_PC`, `id_valid`=0, `id_pc`=0, `id_inst`=`NOP_INST`, `fetch_count`=0, `misalign_err`=0. `imem_addr`=`RESET_PC` in the cycle after reset.
- Redirect (wins over `stall`): `pc` <= `{redirect_pc[31:2],2'b00}`; IF/ID flushed (`id_valid`<=0, `id_inst`<=`NOP_INST`, `id_pc`<=0); `fetch_count` unchanged; if `redirect_pc[1:0]`!=0, `misalign_err`<=1 (cleared only by `rst`).
- Stall (no redirect): `pc`, `id_valid`, `id_pc`, `id_inst`, `fetch_count` all hold; `imem_addr` stays stable.
- Advance: `id_pc`<=`pc`, `id_inst`<=`imem_inst`, `id_valid`<=1, `pc`<=`pc`+4, `fetch_count`<=`fetch_count`+1.
- Arithmetic: `pc`+4 is 32-bit modulo; `32'hFFFF_FFFC` advances to `0`. `fetch_count` wraps `32'hFFFF_FFFF` -> 0. The block does not bound `pc` to ROM size; `imem` indexes `addr[9:2]`.
- `pc[1:0]` is always 00.
- No internal FSM beyond the PC/IF-ID registers; states are {EMPTY (`id_valid`=0), FULL (`id_valid`=1)}: EMPTY->FULL on advance, any->EMPTY on redirect or reset, hold on stall.

## Timing
- `imem_addr` = `pc` combinationally, zero latency; `imem` is treated as combinational.
- Fetch latency: instruction at `pc` appears on `id_inst` one cycle after `pc` is presented.
- Redirect asserted in cycle N: `pc`=target in N+1; `id_valid`=0 in N+1; target instruction on `id_inst` with `id_valid`=1 in N+2 (one bubble).
- Redirect and stall in the same cycle: redirect taken, stall ignored.
- Stall held k cycles: outputs frozen exactly k cycles, then advance resumes from the held `pc`.
- `rst` asserted mid-stream or together with redirect/stall: reset values next cycle, no partial update.

## Test plan
- Reset then free-run with image word0=`0x800000b7`, word1=`0xfff08093`, word2=`0x00108113`: `id_valid`=0 first cycle; then `id_pc`/`id_inst` = 0/`0x800000b7`, 4/`0xfff08093`, 8/`0x00108113`; `fetch_count`=3.
- Stall for 2 cycles while `id_pc`=4: `pc`=8, `id_pc`=4, `fetch_count` frozen for 2 cycles, then `id_pc`=8.
- Redirect to `0x98` while `pc`=`0x74`: next cycle `pc`=`0x98`, `id_valid`=0, `id_inst`=`0x00000013`; following cycle `id_pc`=`0x98`, `id_valid`=1.
- Redirect and stall asserted together, target `0xC0`: redirect taken; self-loop (redirect to `0xC0` every other cycle) keeps `id_pc`=`0xC0` and `fetch_count` incrementing once per two cycles.
- Redirect to `0x0000_0106`: `pc`=`0x104`, `misalign_err`=1 and remains 1 after further redirects until `rst`.
- Force `pc` near top (`RESET_PC`=`0xFFFF_FFF8`): `pc` goes `0xFFFF_FFF8` -> `0xFFFF_FFFC` -> `0x0`; `rst` mid-run returns `pc`=`RESET_PC`, `fetch_count`=0.
